// File: rtl/onchip_memory_port_arbiter.sv
// Round-robin arbiter sharing one on-chip RAM port between m0 (feature engine) and m1 (frame loader).
// Define ONCHIP_ARB_BURST_EN to let a holder keep the grant for up to MAX_BURST consecutive accepts.
module onchip_memory_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic              req0, req1;
  logic              last_grant;
  logic              grant_valid, grant_idx;
  logic              gnt_write;
  logic              rd_pend, rd_owner;
  logic [ADDR_W-1:0] sel_address, hold_address;
  logic [BE_W-1:0]   sel_byteenable, hold_byteenable;
  logic [DATA_W-1:0] sel_writedata, hold_writedata;

`ifdef ONCHIP_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] burst_cnt;
  logic             burst_open;

  // A burst is open only after the holder has been accepted and has budget left.
  assign burst_open = (burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST));
`endif

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant is suppressed during reset so nothing reaches the RAM.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        grant_valid = 1'b1;
        grant_idx   = ~last_grant;
`ifdef ONCHIP_ARB_BURST_EN
        if (burst_open) grant_idx = last_grant;
`endif
      end else if (req0) begin
        grant_valid = 1'b1;
        grant_idx   = 1'b0;
      end else if (req1) begin
        grant_valid = 1'b1;
        grant_idx   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_address    = grant_idx ? m1_address    : m0_address;
    sel_byteenable = grant_idx ? m1_byteenable : m0_byteenable;
    sel_writedata  = grant_idx ? m1_writedata  : m0_writedata;
    gnt_write      = grant_idx ? m1_write      : m0_write;
  end

  assign m0_waitrequest = ~(grant_valid & ~grant_idx);
  assign m1_waitrequest = ~(grant_valid &  grant_idx);

  assign mem_address    = grant_valid ? sel_address    : hold_address;
  assign mem_byteenable = grant_valid ? sel_byteenable : hold_byteenable;
  assign mem_writedata  = grant_valid ? sel_writedata  : hold_writedata;
  assign mem_chipselect = grant_valid;
  assign mem_write      = grant_valid & gnt_write;
  assign mem_clken      = 1'b1;

  // Read return stage: RAM data arrives one cycle after acceptance.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner & ~reset;
  assign m1_readdatavalid = rd_pend &  rd_owner & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant      <= 1'b1;
      rd_pend         <= 1'b0;
      rd_owner        <= 1'b0;
      hold_address    <= '0;
      hold_byteenable <= '0;
      hold_writedata  <= '0;
    end else begin
      rd_pend  <= grant_valid & ~gnt_write;
      rd_owner <= grant_idx;
      if (grant_valid) begin
        last_grant      <= grant_idx;
        hold_address    <= sel_address;
        hold_byteenable <= sel_byteenable;
        hold_writedata  <= sel_writedata;
      end
    end
  end

`ifdef ONCHIP_ARB_BURST_EN
  // Idle cycles close the burst so the next contention alternates.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (grant_valid) begin
      if ((grant_idx == last_grant) && (burst_cnt != '0))
        burst_cnt <= (burst_cnt == CNT_W'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
      else
        burst_cnt <= CNT_W'(1);
    end else begin
      burst_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_onchip_memory_port_arbiter.sv
// Directed bench for onchip_memory_port_arbiter with a behavioural 64Kx32 RAM on the shared port.
module tb_onchip_memory_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onchip_memory_port_arbiter #(
    .ADDR_W(16), .DATA_W(32), .BE_W(4), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // RAM model: address registered on the edge, read data unregistered from the latched address.
  logic [31:0] ram [0:65535];
  logic [15:0] ram_addr_q;
  logic        ram_init;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= {16'hC0DE, 16'(i)};
    end else if (mem_chipselect && mem_clken) begin
      ram_addr_q <= mem_address;
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [15:0] a0;
    logic [31:0] d0;
    logic [3:0]  b0;
    logic        r1, w1;
    logic [15:0] a1;
    logic [31:0] d1;
    logic [3:0]  b1;
    logic [5:0]  ctrl;   // {m0_waitrequest, m1_waitrequest, m0_rdv, m1_rdv, chipselect, write}
    logic [15:0] addr;
    logic        chk;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst,
                     input logic r0, input logic w0, input logic [15:0] a0,
                     input logic [31:0] d0, input logic [3:0] b0,
                     input logic r1, input logic w1, input logic [15:0] a1,
                     input logic [31:0] d1, input logic [3:0] b1,
                     input logic [5:0] ctrl, input logic [15:0] addr,
                     input logic chk, input logic [31:0] rdata);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.b0 = b0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.b1 = b1;
    v.ctrl = ctrl; v.addr = addr; v.chk = chk; v.rdata = rdata;
    tbl.push_back(v);
  endtask

  task automatic drive_idle(input logic rst);
    reset = rst;
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [5:0]  got_ctrl;
    logic [31:0] got_data;
    @(posedge clk); #1;
    reset = v.rst;
    m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_writedata = v.d0; m0_byteenable = v.b0;
    m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_writedata = v.d1; m1_byteenable = v.b1;
    @(negedge clk);
    got_ctrl = {m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
                mem_chipselect, mem_write};
    total++;
    if (got_ctrl !== v.ctrl) begin
      bad++;
      $display("FAIL row%0d ctrl actual=%b required=%b", idx, got_ctrl, v.ctrl);
    end
    total++;
    if (mem_address !== v.addr) begin
      bad++;
      $display("FAIL row%0d mem_address actual=%h required=%h", idx, mem_address, v.addr);
    end
    if (v.chk) begin
      got_data = m0_readdatavalid ? m0_readdata : m1_readdata;
      total++;
      if (got_data !== v.rdata) begin
        bad++;
        $display("FAIL row%0d readdata actual=%h required=%h", idx, got_data, v.rdata);
      end
    end
  endtask

  initial begin
    int g, exp_g;
    drive_idle(1'b1);
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;

    // rst | m0 r w addr data be | m1 r w addr data be | ctrl addr | chk data
    add(1, 1,0,16'h0010,32'h0,4'h0,         0,1,16'h0020,32'h0,4'h0,         6'b110000,16'h0000, 0,32'h0);
    add(0, 0,0,16'h0000,32'h0,4'h0,         0,0,16'h0000,32'h0,4'h0,         6'b110000,16'h0000, 0,32'h0);
    add(0, 0,1,16'h0010,32'hDEADBEEF,4'hF,  0,0,16'h0000,32'h0,4'h0,         6'b010011,16'h0010, 0,32'h0);
    add(0, 1,0,16'h0010,32'h0,4'h0,         0,0,16'h0000,32'h0,4'h0,         6'b010010,16'h0010, 0,32'h0);
    add(0, 0,0,16'h0000,32'h0,4'h0,         0,0,16'h0000,32'h0,4'h0,         6'b111000,16'h0010, 1,32'hDEADBEEF);
    add(0, 0,0,16'h0000,32'h0,4'h0,         0,1,16'h0300,32'hAAAAAAAA,4'hF,  6'b100011,16'h0300, 0,32'h0);
    add(0, 0,0,16'h0000,32'h0,4'h0,         0,1,16'h0300,32'h11223344,4'h3,  6'b100011,16'h0300, 0,32'h0);
    add(0, 1,0,16'h0300,32'h0,4'h0,         0,0,16'h0000,32'h0,4'h0,         6'b010010,16'h0300, 0,32'h0);
    add(0, 0,0,16'h0000,32'h0,4'h0,         0,0,16'h0000,32'h0,4'h0,         6'b111000,16'h0300, 1,32'hAAAA3344);
    // Read accepted, then reset: the pending return is dropped and m0 wins after reset.
    add(0, 1,0,16'h0010,32'h0,4'h0,         0,0,16'h0000,32'h0,4'h0,         6'b010010,16'h0010, 0,32'h0);
    add(1, 1,0,16'h0300,32'h0,4'h0,         1,0,16'h0200,32'h0,4'h0,         6'b110000,16'h0010, 0,32'h0);
    add(0, 1,0,16'h0300,32'h0,4'h0,         1,0,16'h0200,32'h0,4'h0,         6'b010010,16'h0300, 0,32'h0);
    add(0, 0,0,16'h0000,32'h0,4'h0,         0,0,16'h0000,32'h0,4'h0,         6'b111000,16'h0300, 1,32'hAAAA3344);
`ifndef ONCHIP_ARB_BURST_EN
    // Contention: m1 single read sets last_grant, then both masters read for six cycles.
    add(0, 0,0,16'h0000,32'h0,4'h0,         1,0,16'h01FF,32'h0,4'h0,         6'b100010,16'h01FF, 0,32'h0);
    add(0, 1,0,16'h0100,32'h0,4'h0,         1,0,16'h0200,32'h0,4'h0,         6'b010110,16'h0100, 1,32'hC0DE01FF);
    add(0, 1,0,16'h0101,32'h0,4'h0,         1,0,16'h0200,32'h0,4'h0,         6'b101010,16'h0200, 1,32'hC0DE0100);
    add(0, 1,0,16'h0101,32'h0,4'h0,         1,0,16'h0201,32'h0,4'h0,         6'b010110,16'h0101, 1,32'hC0DE0200);
    add(0, 1,0,16'h0102,32'h0,4'h0,         1,0,16'h0201,32'h0,4'h0,         6'b101010,16'h0201, 1,32'hC0DE0101);
    add(0, 1,0,16'h0102,32'h0,4'h0,         1,0,16'h0202,32'h0,4'h0,         6'b010110,16'h0102, 1,32'hC0DE0201);
    add(0, 1,0,16'h0103,32'h0,4'h0,         1,0,16'h0202,32'h0,4'h0,         6'b101010,16'h0202, 1,32'hC0DE0102);
    add(0, 0,0,16'h0000,32'h0,4'h0,         0,0,16'h0000,32'h0,4'h0,         6'b110100,16'h0202, 1,32'hC0DE0202);
`endif

    foreach (tbl[i]) apply(tbl[i], i);

    // Grant pattern with both masters requesting continuously from reset.
    @(posedge clk); #1;
    drive_idle(1'b1);
    @(posedge clk); #1;
    drive_idle(1'b0);
    m0_read = 1'b1; m0_address = 16'h0400;
    m1_read = 1'b1; m1_address = 16'h0500;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      g = (!m0_waitrequest && m1_waitrequest) ? 0 :
          (!m1_waitrequest && m0_waitrequest) ? 1 : 2;
`ifdef ONCHIP_ARB_BURST_EN
      exp_g = (i / 4) % 2;
`else
      exp_g = i % 2;
`endif
      total++;
      if (g != exp_g) begin
        bad++;
        $display("FAIL pattern cycle%0d grant actual=%0d required=%0d", i, g, exp_g);
      end
      @(posedge clk); #1;
    end
    drive_idle(1'b0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
